// File: rtl/ring_pkg.sv
// Shared types and sizing helpers for the ring buffer FIFO and its drain stages.
package ring_pkg;

  typedef enum logic [0:0] {S_IDLE, S_SEND} ser_state_t;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    w = int'($clog2(n));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX counter with synchronous clear (priority) and increment enable.
module wrap_counter
  import ring_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [cnt_w(MAX)-1:0] count,
  output logic                  at_max
);

  localparam int unsigned W = cnt_w(MAX);

  logic [W-1:0] count_q, count_d;

  assign at_max = (count_q == W'(MAX - 1));
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = at_max ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/ring_stream_serializer.sv
// Pops words from the ring FIFO's show-ahead head and streams them out as
// LSB-first slices, flagging the last slice of every PKT_WORDS-word packet.
module ring_stream_serializer
  import ring_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 2,
  parameter int unsigned PKT_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [IN_WIDTH-1:0]  fifo_head,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned SLICES = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned SW     = cnt_w(SLICES);
  localparam int unsigned PW     = cnt_w(PKT_WORDS);

  ser_state_t          state_q, state_d;
  logic [IN_WIDTH-1:0] shift_q, shift_d;

  logic          fetch, acc, pop;
  logic          slice_clr, slice_inc, slice_at_max;
  logic          pkt_clr, pkt_inc, pkt_at_max;
  logic [SW-1:0] slice_cnt;
  logic [PW-1:0] pkt_cnt;
  logic          unused_cnt;

  assign fetch = enable & ~fifo_empty & ~clear;
  assign busy  = (state_q == S_SEND);
  assign acc   = busy & out_ready;

  assign out_valid = busy;
  assign out_data  = busy ? shift_q[OUT_WIDTH-1:0] : '0;
  assign out_last  = busy & slice_at_max & pkt_at_max;
  // Pop is suppressed while reset is held so the FIFO head never advances.
  assign fifo_pop  = pop & rst_n;

  // Counter values are only consumed through their wrap flags.
  assign unused_cnt = ^{slice_cnt, pkt_cnt};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    slice_clr = 1'b0;
    slice_inc = 1'b0;
    pkt_clr   = 1'b0;
    pkt_inc   = 1'b0;
    if (clear) begin
      state_d   = S_IDLE;
      shift_d   = '0;
      slice_clr = 1'b1;
      pkt_clr   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fetch) begin
            pop       = 1'b1;
            shift_d   = fifo_head;
            slice_clr = 1'b1;
            state_d   = S_SEND;
          end
        end
        S_SEND: begin
          if (acc && !slice_at_max) begin
            shift_d   = shift_q >> OUT_WIDTH;
            slice_inc = 1'b1;
          end else if (acc) begin
            // Word done: chain straight into the next word when one is ready.
            pkt_inc = 1'b1;
            if (fetch) begin
              pop       = 1'b1;
              shift_d   = fifo_head;
              slice_clr = 1'b1;
            end else begin
              slice_inc = 1'b1;
              state_d   = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

  wrap_counter #(.MAX(SLICES)) u_slice_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (slice_clr),
    .inc    (slice_inc),
    .count  (slice_cnt),
    .at_max (slice_at_max)
  );

  wrap_counter #(.MAX(PKT_WORDS)) u_pkt_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (pkt_clr),
    .inc    (pkt_inc),
    .count  (pkt_cnt),
    .at_max (pkt_at_max)
  );

endmodule

// File: tb/tb_ring_stream_serializer.sv
// Scoreboard bench for ring_stream_serializer with a behavioural show-ahead FIFO.
module tb_ring_stream_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clear;
  logic [7:0] fifo_head;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  typedef struct packed {
    logic [1:0] d;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   pop_log[$];
  int   checks = 0;
  int   errors = 0;
  int   tb_pkt = 0;
  int   cyc = 0;
  int   pop_cnt = 0;

  logic [7:0]  fifo_mem [0:255];
  int unsigned rd = 0;
  int unsigned wr = 0;

  assign fifo_head  = fifo_mem[rd[7:0]];
  assign fifo_empty = (rd == wr);

  always #5 clk = ~clk;

  ring_stream_serializer #(.IN_WIDTH(8), .OUT_WIDTH(2), .PKT_WORDS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .clear      (clear),
    .fifo_head  (fifo_head),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_pop) begin
      rd      <= rd + 1;
      pop_cnt <= pop_cnt + 1;
      pop_log.push_back(cyc);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted slice must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_slice", {29'd0, out_data, out_last}, -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("slice_data_last", {29'd0, out_data, out_last}, {29'd0, e.d, e.l});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [7:0] w);
    fifo_mem[wr[7:0]] = w;
    wr = wr + 1;
  endtask

  task automatic exp_push(input logic [1:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic exp_word(input logic [7:0] w);
    logic [7:0] s;
    s = w;
    for (int k = 0; k < 4; k++) begin
      exp_push(s[1:0], (k == 3) && (tb_pkt == 3));
      s = s >> 2;
    end
    tb_pkt = (tb_pkt + 1) % 4;
  endtask

  task automatic send_word(input logic [7:0] w);
    fifo_write(w);
    exp_word(w);
  endtask

  // Runs until the FIFO is drained and the block is idle; reports valid cycles and their span.
  task automatic wait_idle(output int nvalid, output int span);
    int first_v, last_v;
    bit done;
    nvalid = 0; first_v = -1; last_v = -1; done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (out_valid) begin
        nvalid++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      if (!out_valid && !busy && rd == wr && i > 0) done = 1;
    end
    if (!done) check("idle_timeout", 0, 1);
    span = (first_v < 0) ? 0 : last_v - first_v + 1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, sp, pc0;
    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; out_ready = 1'b1;

    // Reset with data waiting: everything quiet, no pop.
    fifo_write(8'h39);
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_pop", fifo_pop, 0);
    tick();
    rst_n = 1'b1;
    exp_word(8'h39);
    @(negedge clk);
    check("pop_after_reset", fifo_pop, 1);
    wait_idle(nv, sp);

    // Single word 0xB4: slices 0,1,3,2.
    pc0 = pop_cnt;
    fifo_write(8'hB4);
    exp_push(2'd0, 1'b0); exp_push(2'd1, 1'b0); exp_push(2'd3, 1'b0); exp_push(2'd2, 1'b0);
    tb_pkt = tb_pkt + 1;
    wait_idle(nv, sp);
    check("single_pop_count", pop_cnt - pc0, 1);
    check("single_valid_cycles", nv, 4);
    check("single_valid_span", sp, 4);
    @(negedge clk);
    check("single_valid_after", out_valid, 0);
    tick();

    // Backpressure at slice 1 for three cycles.
    fifo_write(8'hB4);
    exp_push(2'd0, 1'b0); exp_push(2'd1, 1'b0); exp_push(2'd3, 1'b0); exp_push(2'd2, 1'b0);
    tb_pkt = tb_pkt + 1;
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid_hold", out_valid, 1);
      check("bp_data_hold", out_data, 1);
      check("bp_last_hold", out_last, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle(nv, sp);

    // Idle clear realigns packet position.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tb_pkt = 0;

    // Back-to-back packet of four words.
    pop_log.delete();
    send_word(8'h00); send_word(8'h01); send_word(8'h02); send_word(8'h03);
    wait_idle(nv, sp);
    check("b2b_valid_cycles", nv, 16);
    check("b2b_valid_span", sp, 16);
    check("b2b_pop_count", pop_log.size(), 4);
    if (pop_log.size() == 4) begin
      for (int i = 1; i < 4; i++) check("b2b_pop_spacing", pop_log[i] - pop_log[i-1], 4);
    end

    // FIFO runs empty mid-packet, packet resumes after the gap.
    send_word(8'hE4); send_word(8'h1B);
    wait_idle(nv, sp);
    check("gap_first_half_cycles", nv, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gap_valid_low", out_valid, 0);
      tick();
    end
    send_word(8'h5A); send_word(8'hA5);
    wait_idle(nv, sp);
    check("gap_second_half_cycles", nv, 8);

    // Clear while slice 2 of 0xB4 is presented.
    fifo_write(8'hB4);
    exp_push(2'd0, 1'b0); exp_push(2'd1, 1'b0);
    tick(); tick(); tick();
    out_ready = 1'b0;
    clear = 1'b1;
    fifo_write(8'h1B);
    @(negedge clk);
    check("clear_slice2_data", out_data, 3);
    check("pop_in_clear", fifo_pop, 0);
    tick();
    clear = 1'b0;
    out_ready = 1'b1;
    tb_pkt = 0;
    exp_word(8'h1B);
    @(negedge clk);
    check("valid_after_clear", out_valid, 0);
    check("pop_after_clear", fifo_pop, 1);
    tick();
    @(negedge clk);
    check("first_slice_after_clear", out_data, 3);
    check("busy_after_clear", busy, 1);
    tick();
    send_word(8'h02); send_word(8'h03); send_word(8'hFF);
    wait_idle(nv, sp);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
